// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// Define UART_TX_B2B_EN to accept a new byte during the stop bit.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CW = ($clog2(DATA_WIDTH + 1) > 1) ? $clog2(DATA_WIDTH + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic                  sd_q, sd_d;
    logic [1:0]            mux_q, mux_d;
    logic                  busy_q, busy_d;
    logic                  accept;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        sd_d     = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: accept = Data_Valid;
            START: begin
                // Present bit 0 on entry so each DATA cycle k shows bit k
                state_d = DATA;
                cnt_d   = '0;
                sd_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    sd_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                state_d = IDLE;
`ifdef UART_TX_B2B_EN
                accept = Data_Valid;
`else
                accept = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d  = START;
            shift_d  = P_DATA;
            par_en_d = PAR_EN;
            par_d    = PAR_TYP ? ~^P_DATA : ^P_DATA;
        end
        unique case (state_d)
            START:   mux_d = 2'b00;
            DATA:    mux_d = 2'b10;
            PARITY:  mux_d = 2'b11;
            default: mux_d = 2'b01;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            sd_q     <= 1'b0;
            mux_q    <= 2'b01;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            sd_q     <= sd_d;
            mux_q    <= mux_d;
            busy_q   <= busy_d;
        end
    end

    assign mux_sel  = mux_q;
    assign ser_data = sd_q;
    assign par_bit  = par_q;
    assign busy     = busy_q;

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Frame controller and serializer for the UART transmitter. It sits directly upstream of the TX output multiplexer. It accepts a parallel byte with its parity configuration and sequences start, data (LSB first), optional parity, and stop bits, one per clock. For each bit it drives the multiplexer's 2-bit select together with the serial data bit and the computed parity bit. The clock is the TX baud clock, so each bit lasts exactly one cycle.

## Interface

- DATA_WIDTH, 8, payload bits per frame; legal range ≥1.

- CLK  in  1  TX baud clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  parallel payload; sampled only on accept.
- Data_Valid  in  1  request to send P_DATA; single-cycle or level.
- PAR_EN  in  1  1 = append parity bit; sampled on accept.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on accept.
- mux_sel  out  2  00 start, 01 stop/idle, 10 serial data, 11 parity.
- ser_data  out  1  current payload bit; meaningful when mux_sel = 10.
- par_bit  out  1  parity of latched payload; meaningful when mux_sel = 11.
- busy  out  1  high from first start-bit cycle through last stop-bit cycle.

## Operation

- **States:** IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- **Reset values:** state = IDLE, mux_sel = 01, busy = 0, ser_data = 0, par_bit = 0. Shift register and bit counter = 0.
- **IDLE:** mux_sel = 01, busy = 0. If Data_Valid = 1 at an edge:
  - latch P_DATA into the shift register;
  - latch PAR_EN;
  - compute par_bit = ^P_DATA (even) or ~^P_DATA (odd) from PAR_TYP;
  - go to START.
- **START:** mux_sel = 00, busy = 1, for one cycle, then go to DATA with bit counter = 0.
- **DATA:** mux_sel = 10, ser_data = shift register bit 0.
  - Each edge shifts right and increments the counter.
  - After DATA_WIDTH cycles, go to PARITY if latched PAR_EN = 1, else STOP.
- **PARITY:** mux_sel = 11 for one cycle, par_bit held, then go to STOP.
- **STOP:** mux_sel = 01, busy = 1 for one cycle, then go to IDLE (busy = 0).
- **Ignored inputs:** Data_Valid is ignored in every state except IDLE, and in STOP unless the back-to-back option is enabled. There is no queueing. P_DATA, PAR_EN and PAR_TYP changes after accept do not affect the frame in flight.
- **Bit counter:** width is max(1, $clog2(DATA_WIDTH+1)). It never wraps within a frame.
- **Parity hold:** par_bit keeps its value until the next accept.

## Timing

- **Accept latency:** Data_Valid sampled high in IDLE at edge N gives mux_sel = 00 and busy = 1 after edge N.
- **Frame length:** 1 + DATA_WIDTH + PAR_EN + 1 cycles. That is 11 cycles with parity and 10 without, at DATA_WIDTH = 8.
- **Data bits:** payload bit k is presented on ser_data during DATA cycle k (k = 0 first).
- **Busy fall:** busy falls on the edge that leaves STOP. A Data_Valid held high then starts the next frame one edge later, giving exactly one idle cycle between frames (default build).
- **Reset:**
  - RST high at any edge forces all reset values after that edge, including mid-frame. The line returns to stop level on the following cycle.
  - Data_Valid is ignored while RST = 1.
  - RST has priority over accept.

## Configuration

- **UART_TX_B2B_EN:**
  - **Defined:** a Data_Valid sampled during the STOP cycle is accepted exactly as in IDLE (latch and parity compute), and the next state is START. busy stays 1 and there are no idle cycles between frames.
  - **Undefined:** Data_Valid in STOP is ignored, and at least one IDLE cycle (mux_sel = 01, busy = 0) separates frames.

## Test plan

- **Reset:** RST = 1 for 2 cycles mid-frame (during DATA bit 3) -> next edge mux_sel = 01, busy = 0, ser_data = 0, par_bit = 0. A new Data_Valid afterwards produces a complete clean frame.
- **Even parity:** P_DATA = 8'hA5, PAR_EN = 1, PAR_TYP = 0 -> mux_sel sequence 00, 10×8, 11, 01. ser_data = 1,0,1,0,0,1,0,1; par_bit = 0; busy high exactly 11 cycles.
- **No parity:** P_DATA = 8'h01, PAR_EN = 0 -> 10-cycle frame with no 11 select. ser_data = 1 then 0×7.
- **Odd parity:** P_DATA = 8'h07, PAR_TYP = 1, PAR_EN = 1 -> par_bit = 0. P_DATA = 8'h03 gives par_bit = 1.
- **Mid-frame changes:** Data_Valid pulsed with P_DATA = 8'hFF, and PAR_EN toggled, during DATA -> in-flight frame unchanged. No second frame starts.
- **Back-to-back:** Data_Valid held high, frames 8'h55 then 8'hAA -> one idle cycle between frames by default. With UART_TX_B2B_EN, STOP is followed directly by START and busy never drops.
